// File: rtl/sram_1r1w_init.sv
// sram_1r1w_init: 1R1W SRAM model with byte-lane write mask, write-to-read bypass, optional output register and hardware fill engine
module sram_1r1w_init #(
   parameter int                DATA_W   = 64,
   parameter int                DEPTH    = 512,
   parameter int                ADDR_W   = 9,
   parameter int                MASK_W   = 8,
   parameter int                OUT_REG  = 0,
   parameter int                BYPASS   = 1,
   parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              init_req,
   output logic              busy,
   input  logic              W0_en,
   input  logic [ADDR_W-1:0] W0_addr,
   input  logic [DATA_W-1:0] W0_data,
   input  logic [MASK_W-1:0] W0_mask,
   input  logic              R0_en,
   input  logic [ADDR_W-1:0] R0_addr,
   output logic [DATA_W-1:0] R0_data,
   output logic              R0_valid
);
   localparam int                LANE_W  = DATA_W / MASK_W;
   localparam logic [ADDR_W:0]   DEPTH_X = (ADDR_W + 1)'(DEPTH);
   localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);

   typedef enum logic {FILL, IDLE} state_t;

   state_t            state, state_nxt;
   logic [ADDR_W-1:0] cnt, cnt_nxt;
   logic [DATA_W-1:0] mem [DEPTH];
   logic              idle, wr_ok, rd_ok, rd_in, collide, fill_we;
   logic [DATA_W-1:0] rd_raw, rd_val;

   // the fill engine owns the array until the last entry is written; busy is a straight decode of the state flop
   assign idle    = state == IDLE;
   assign busy    = state == FILL;
   assign fill_we = busy && reset_n;
   assign wr_ok   = idle && W0_en && ({1'b0, W0_addr} < DEPTH_X);
   assign rd_in   = {1'b0, R0_addr} < DEPTH_X;
   assign rd_ok   = idle && R0_en;
   assign collide = (BYPASS != 0) && wr_ok && (W0_addr == R0_addr);

   // state and fill counter
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state <= FILL;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // next state: walk every entry once, then wait in IDLE for a fill request
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      if (state == FILL) begin
         cnt_nxt   = (cnt == LAST) ? '0 : cnt + 1'b1;
         state_nxt = (cnt == LAST) ? IDLE : FILL;
      end else if (init_req) begin
         state_nxt = FILL;
         cnt_nxt   = '0;
      end
   end

   // read mux: out-of-range returns the fill value; bypass overlays only the lanes being written
   always_comb begin
      rd_raw = rd_in ? mem[R0_addr] : INIT_VAL;
      rd_val = rd_raw;
      for (int i = 0; i < MASK_W; i++)
         if (collide && W0_mask[i]) rd_val[i*LANE_W +: LANE_W] = W0_data[i*LANE_W +: LANE_W];
   end

   // array update: fill writes whole words, port writes honour the lane mask; reset never clears contents
   always_ff @(posedge clock) begin
      if (fill_we)
         mem[cnt] <= INIT_VAL;
      else if (wr_ok)
         for (int i = 0; i < MASK_W; i++)
            if (W0_mask[i]) mem[W0_addr][i*LANE_W +: LANE_W] <= W0_data[i*LANE_W +: LANE_W];
   end

   generate
      if (OUT_REG != 0) begin : g_pipe
         logic              s1_valid;
         logic [DATA_W-1:0] s1_data;
         // two-stage read return; data registers hold their value between reads
         always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
               s1_valid <= 1'b0;
               s1_data  <= '0;
               R0_valid <= 1'b0;
               R0_data  <= '0;
            end else begin
               s1_valid <= rd_ok;
               R0_valid <= s1_valid;
               if (rd_ok) s1_data <= rd_val;
               if (s1_valid) R0_data <= s1_data;
            end
         end
      end else begin : g_flat
         // single-stage read return; data register holds its value between reads
         always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
               R0_valid <= 1'b0;
               R0_data  <= '0;
            end else begin
               R0_valid <= rd_ok;
               if (rd_ok) R0_data <= rd_val;
            end
         end
      end
   endgenerate
endmodule

// File: tb/tb_sram_1r1w_init.sv
// tb_sram_1r1w_init: scoreboard bench driving a default instance and a DEPTH=300/OUT_REG=1/BYPASS=0 instance with one stimulus stream
module tb_sram_1r1w_init;
   localparam logic [63:0] IV = 64'hDEAD_BEEF_0BAD_F00D;

   typedef struct {
      logic [63:0] d;
      int          due;
   } exp_t;

   logic        clock = 1'b0, reset_n = 1'b0, init_req = 1'b0;
   logic        w_en = 1'b0, r_en = 1'b0;
   logic [8:0]  w_addr = '0, r_addr = '0;
   logic [63:0] w_data = '0;
   logic [7:0]  w_mask = '0;
   logic        a_busy, a_valid, b_busy, b_valid;
   logic [63:0] a_data, b_data;
   int          checks = 0, failures = 0, cyc = 0;
   exp_t        qa[$], qb[$];
   exp_t        ea_e, eb_e;
   logic [63:0] ma [512];
   logic [63:0] mb [300];

   sram_1r1w_init #(.INIT_VAL(IV)) dut_a (
      .clock(clock), .reset_n(reset_n), .init_req(init_req), .busy(a_busy),
      .W0_en(w_en), .W0_addr(w_addr), .W0_data(w_data), .W0_mask(w_mask),
      .R0_en(r_en), .R0_addr(r_addr), .R0_data(a_data), .R0_valid(a_valid)
   );

   sram_1r1w_init #(.DEPTH(300), .OUT_REG(1), .BYPASS(0), .INIT_VAL(IV)) dut_b (
      .clock(clock), .reset_n(reset_n), .init_req(init_req), .busy(b_busy),
      .W0_en(w_en), .W0_addr(w_addr), .W0_data(w_data), .W0_mask(w_mask),
      .R0_en(r_en), .R0_addr(r_addr), .R0_data(b_data), .R0_valid(b_valid)
   );

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] d, input logic [7:0] m);
      for (int i = 0; i < 8; i++) if (m[i]) old[i*8 +: 8] = d[i*8 +: 8];
      return old;
   endfunction

   // scoreboard pop: every valid pulse must match the oldest expectation in data and arrival cycle
   always @(negedge clock) if (reset_n) begin
      if (a_valid) begin
         if (qa.size() == 0) chk("a_spurious_valid", 64'd1, 64'd0);
         else begin
            ea_e = qa.pop_front();
            chk("a_data", a_data, ea_e.d);
            chk("a_latency", 64'(cyc), 64'(ea_e.due));
         end
      end
      if (b_valid) begin
         if (qb.size() == 0) chk("b_spurious_valid", 64'd1, 64'd0);
         else begin
            eb_e = qb.pop_front();
            chk("b_data", b_data, eb_e.d);
            chk("b_latency", 64'(cyc), 64'(eb_e.due));
         end
      end
   end

   task automatic op(input logic we, input logic [8:0] wa, input logic [63:0] wd, input logic [7:0] wm,
                     input logic re, input logic [8:0] ra);
      logic [63:0] ea, eb;
      w_en = we; w_addr = wa; w_data = wd; w_mask = wm; r_en = re; r_addr = ra;
      if (re) begin
         ea = ma[ra];
         if (we && wa == ra) ea = merge(ea, wd, wm);
         eb = IV;
         if (ra < 300) eb = mb[ra];
         qa.push_back('{ea, cyc + 1});
         qb.push_back('{eb, cyc + 2});
      end
      if (we) begin
         ma[wa] = merge(ma[wa], wd, wm);
         if (wa < 300) mb[wa] = merge(mb[wa], wd, wm);
      end
      @(posedge clock); #1;
      w_en = 1'b0; r_en = 1'b0;
   endtask

   task automatic wait_fill(input logic inj);
      int n = 0, na = -1, nb = -1;
      while ((a_busy || b_busy) && n < 2000) begin
         if (inj && n == 150) begin
            w_en = 1'b1; w_addr = 9'd0; w_data = 64'h5555_5555_5555_5555; w_mask = 8'hFF;
            r_en = 1'b1; r_addr = 9'd1;
         end
         if (inj && n == 160) init_req = 1'b1;
         @(posedge clock); #1;
         n++;
         w_en = 1'b0; r_en = 1'b0; init_req = 1'b0;
         if (!a_busy && na < 0) na = n;
         if (!b_busy && nb < 0) nb = n;
      end
      chk("a_fill_cycles", 64'(na), 64'd512);
      chk("b_fill_cycles", 64'(nb), 64'd300);
      for (int i = 0; i < 512; i++) ma[i] = IV;
      for (int i = 0; i < 300; i++) mb[i] = IV;
   endtask

   task automatic drain();
      int k = 0;
      while ((qa.size() != 0 || qb.size() != 0) && k < 20) begin
         @(negedge clock); #1;
         k++;
      end
      chk("a_drain", 64'(qa.size()), 64'd0);
      chk("b_drain", 64'(qb.size()), 64'd0);
   endtask

   task automatic reset_checks();
      chk("a_rst_busy", 64'(a_busy), 64'd1);
      chk("b_rst_busy", 64'(b_busy), 64'd1);
      chk("a_rst_valid", 64'(a_valid), 64'd0);
      chk("b_rst_valid", 64'(b_valid), 64'd0);
      chk("a_rst_data", a_data, 64'd0);
      chk("b_rst_data", b_data, 64'd0);
   endtask

   initial begin
      repeat (3) @(posedge clock);
      #1;
      reset_checks();
      reset_n = 1'b1;
      wait_fill(1'b0);
      op(0, 0, 0, 0, 1, 9'd0);
      op(0, 0, 0, 0, 1, 9'd255);
      op(0, 0, 0, 0, 1, 9'd511);
      op(1, 9'd5, 64'h1122_3344_5566_7788, 8'hFF, 0, 0);
      op(1, 9'd5, 64'hAAAA_AAAA_AAAA_AAAA, 8'h0F, 0, 0);
      op(0, 0, 0, 0, 1, 9'd5);
      op(1, 9'd7, 64'hFFFF_FFFF_FFFF_FFFF, 8'h01, 1, 9'd7);
      op(0, 0, 0, 0, 1, 9'd7);
      op(1, 9'd5, 64'h0123_4567_89AB_CDEF, 8'h00, 1, 9'd5);
      op(1, 9'd400, 64'hCAFE_0000_1234_5678, 8'hFF, 0, 0);
      op(0, 0, 0, 0, 1, 9'd400);
      op(0, 0, 0, 0, 1, 9'd144);
      for (int i = 0; i < 16; i++) op(1, 9'(i), {$urandom, $urandom}, 8'hFF, 0, 0);
      for (int i = 0; i < 16; i++) op(0, 0, 0, 0, 1, 9'(i));
      drain();
      op(1, 9'd10, 64'h0F0F_0F0F_F0F0_F0F0, 8'hFF, 0, 0);
      init_req = 1'b1;
      op(1, 9'd20, 64'h7777_8888_9999_AAAA, 8'hFF, 1, 9'd10);
      init_req = 1'b0;
      repeat (100) @(posedge clock);
      #3 reset_n = 1'b0;
      #1 reset_checks();
      @(posedge clock); #1;
      reset_n = 1'b1;
      wait_fill(1'b1);
      op(0, 0, 0, 0, 1, 9'd0);
      op(0, 0, 0, 0, 1, 9'd10);
      op(0, 0, 0, 0, 1, 9'd20);
      drain();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
